// File: rtl/router_ctrl_fsm.sv
// Packet sequencer for the 1-in/3-out router: header decode, register-stage phase strobes, FIFO write enables,
// per-port read-timeout soft reset. Optional per-port packet counters when ROUTER_PKT_CNT_EN is defined.
module router_ctrl_fsm #(
   parameter int TIMEOUT = 30,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        pkt_valid,
   input  logic [1:0]  addr,
   input  logic [2:0]  fifo_full_vec,
   input  logic [2:0]  fifo_empty_vec,
   input  logic [2:0]  read_enb,
   input  logic        parity_done,
   input  logic        low_pkt_valid,
   output logic        fifo_full,
   output logic        detect_addr,
   output logic        lfd_state,
   output logic        ld_state,
   output logic        laf_state,
   output logic        full_state,
   output logic        rst_int_reg,
   output logic        write_enb_reg,
   output logic [2:0]  write_enb,
   output logic        busy,
   output logic [2:0]  vld_out,
   output logic [2:0]  soft_reset,
   output logic [23:0] pkt_count
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS,
      WAIT_TILL_EMPTY,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      LOAD_PARITY,
      CHECK_PARITY_ERROR
   } state_t;

   state_t     r_state;
   logic [1:0] r_port_sel;
   logic       w_hdr_ok;
   logic       w_abort;

   assign w_hdr_ok  = pkt_valid && (addr != 2'd3);
   assign w_abort   = soft_reset[r_port_sel];
   assign fifo_full = fifo_full_vec[r_port_sel];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= DECODE_ADDRESS;
         r_port_sel <= 2'd0;
      end else if (r_state != DECODE_ADDRESS && w_abort) begin
         r_state <= DECODE_ADDRESS;
      end else begin
         case (r_state)
            DECODE_ADDRESS: begin
               if (w_hdr_ok) begin
                  r_port_sel <= addr;
                  r_state    <= fifo_empty_vec[addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
               end
            end
            WAIT_TILL_EMPTY:
               if (fifo_empty_vec[r_port_sel]) r_state <= LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:
               r_state <= LOAD_DATA;
            LOAD_DATA: begin
               if (fifo_full)       r_state <= FIFO_FULL_STATE;
               else if (!pkt_valid) r_state <= LOAD_PARITY;
            end
            FIFO_FULL_STATE:
               if (!fifo_full) r_state <= LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
               if (parity_done)        r_state <= DECODE_ADDRESS;
               else if (low_pkt_valid) r_state <= LOAD_PARITY;
               else                    r_state <= LOAD_DATA;
            end
            LOAD_PARITY:
               r_state <= CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
               r_state <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:
               r_state <= DECODE_ADDRESS;
         endcase
      end
   end

   assign detect_addr   = (r_state == DECODE_ADDRESS);
   assign lfd_state     = (r_state == LOAD_FIRST_DATA);
   assign ld_state      = (r_state == LOAD_DATA);
   assign laf_state     = (r_state == LOAD_AFTER_FULL);
   assign full_state    = (r_state == FIFO_FULL_STATE);
   assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
   assign write_enb_reg = ld_state || laf_state || (r_state == LOAD_PARITY);
   assign write_enb     = write_enb_reg ? (3'b001 << r_port_sel) : 3'b000;
   assign busy          = !(detect_addr || ld_state);
   assign vld_out       = ~fifo_empty_vec;

   // A read in the terminal-count cycle clears the counter and suppresses the pulse.
   for (genvar g = 0; g < 3; g++) begin : g_tmo
      logic [CNT_W-1:0] r_cnt;
      logic             r_sr;

      always_ff @(posedge clk) begin
         if (!rstn) begin
            r_cnt <= '0;
            r_sr  <= 1'b0;
         end else if (fifo_empty_vec[g] || read_enb[g]) begin
            r_cnt <= '0;
            r_sr  <= 1'b0;
         end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_cnt <= '0;
            r_sr  <= 1'b1;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_sr  <= 1'b0;
         end
      end

      assign soft_reset[g] = r_sr;
   end

`ifdef ROUTER_PKT_CNT_EN
   logic [2:0][7:0] r_pkt_cnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_pkt_cnt <= '0;
      end else if (r_state == CHECK_PARITY_ERROR) begin
         r_pkt_cnt[r_port_sel] <= r_pkt_cnt[r_port_sel] + 8'd1;
      end
   end

   assign pkt_count = r_pkt_cnt;
`else
   assign pkt_count = 24'd0;
`endif

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Self-checking bench for router_ctrl_fsm: directed scenarios plus random traffic against a behavioural model.
module tb_router_ctrl_fsm;
   localparam int TIMEOUT = 30;
   localparam int CNT_W   = 5;
   localparam int P_DEC = 0, P_WTE = 1, P_LFD = 2, P_LD = 3, P_FF = 4, P_LAF = 5, P_LP = 6, P_CPE = 7;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        pkt_valid = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [2:0]  fifo_full_vec = 3'b000;
   logic [2:0]  fifo_empty_vec = 3'b111;
   logic [2:0]  read_enb = 3'b000;
   logic        parity_done = 1'b0;
   logic        low_pkt_valid = 1'b0;
   logic        fifo_full, detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
   logic        write_enb_reg, busy;
   logic [2:0]  write_enb, vld_out, soft_reset;
   logic [23:0] pkt_count;

   int checks = 0;
   int failures = 0;

   // Behavioural model: packet phase, selected port, unread run length, pulse flags, packet counts.
   int m_ph = P_DEC;
   int m_sel = 0;
   int m_run[3] = '{0, 0, 0};
   bit m_sr[3] = '{0, 0, 0};
   int m_cnt[3] = '{0, 0, 0};

   always #5 clk = ~clk;

   router_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .addr(addr),
      .fifo_full_vec(fifo_full_vec), .fifo_empty_vec(fifo_empty_vec), .read_enb(read_enb),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
      .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg),
      .write_enb(write_enb), .busy(busy), .vld_out(vld_out), .soft_reset(soft_reset),
      .pkt_count(pkt_count)
   );

   task automatic model_update();
      int nx;
      bit full;
      if (!rstn) begin
         m_ph = P_DEC;
         m_sel = 0;
         for (int i = 0; i < 3; i++) begin
            m_run[i] = 0; m_sr[i] = 0; m_cnt[i] = 0;
         end
         return;
      end
      full = fifo_full_vec[m_sel];
      case (m_ph)
         P_DEC:   nx = (pkt_valid && addr != 2'd3) ? (fifo_empty_vec[addr] ? P_LFD : P_WTE) : P_DEC;
         P_WTE:   nx = fifo_empty_vec[m_sel] ? P_LFD : P_WTE;
         P_LFD:   nx = P_LD;
         P_LD:    nx = full ? P_FF : (!pkt_valid ? P_LP : P_LD);
         P_FF:    nx = full ? P_FF : P_LAF;
         P_LAF:   nx = parity_done ? P_DEC : (low_pkt_valid ? P_LP : P_LD);
         P_LP:    nx = P_CPE;
         default: nx = full ? P_FF : P_DEC;
      endcase
      if (m_ph != P_DEC && m_sr[m_sel]) nx = P_DEC;
      if (m_ph == P_CPE) m_cnt[m_sel] = (m_cnt[m_sel] + 1) % 256;
      if (m_ph == P_DEC && pkt_valid && addr != 2'd3) m_sel = int'(addr);
      m_ph = nx;
      // A pulse follows the TIMEOUT-th consecutive unread non-empty cycle.
      for (int i = 0; i < 3; i++) begin
         if (fifo_empty_vec[i] || read_enb[i]) begin
            m_run[i] = 0; m_sr[i] = 0;
         end else begin
            m_run[i] = m_run[i] + 1;
            m_sr[i] = (m_run[i] == TIMEOUT);
            if (m_sr[i]) m_run[i] = 0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   function automatic logic [41:0] exp_vec();
      logic [2:0]  we;
      logic [2:0]  sr;
      logic [23:0] pc;
      logic        wer;
      wer = (m_ph == P_LD) || (m_ph == P_LP) || (m_ph == P_LAF);
      we = 3'b000;
      if (wer) we[m_sel] = 1'b1;
      for (int i = 0; i < 3; i++) sr[i] = m_sr[i];
      pc = '0;
`ifdef ROUTER_PKT_CNT_EN
      for (int i = 0; i < 3; i++) pc[i*8 +: 8] = 8'(m_cnt[i]);
`endif
      return {fifo_full_vec[m_sel], m_ph == P_DEC, m_ph == P_LFD, m_ph == P_LD, m_ph == P_LAF,
              m_ph == P_FF, m_ph == P_CPE, wer, we, !(m_ph == P_DEC || m_ph == P_LD),
              ~fifo_empty_vec, sr, pc};
   endfunction

   function automatic logic [41:0] dut_vec();
      return {fifo_full, detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
              write_enb_reg, write_enb, busy, vld_out, soft_reset, pkt_count};
   endfunction

   function automatic int obs_phase();
      if (detect_addr)   return P_DEC;
      if (lfd_state)     return P_LFD;
      if (ld_state)      return P_LD;
      if (laf_state)     return P_LAF;
      if (full_state)    return P_FF;
      if (rst_int_reg)   return P_CPE;
      if (write_enb_reg) return P_LP;
      if (busy)          return P_WTE;
      return -1;
   endfunction

   task automatic test_reset();
      rstn = 1'b0; pkt_valid = 1'b0; fifo_empty_vec = 3'b111; fifo_full_vec = 3'b000; read_enb = 3'b000;
      step(); step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
         failures++; $display("FAIL reset_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      checks++;
      if ({detect_addr, busy, write_enb, soft_reset, pkt_count} !== {1'b1, 1'b0, 3'b000, 3'b000, 24'd0}) begin
         failures++;
         $display("FAIL reset_state got=%b exp=1_0_000_000_0", {detect_addr, busy, write_enb, soft_reset});
      end
      rstn = 1'b1;
   endtask

   task automatic test_basic_packet();
      int exp_ph[7] = '{P_LFD, P_LD, P_LD, P_LD, P_LP, P_CPE, P_DEC};
      pkt_valid = 1'b1; addr = 2'd1; fifo_empty_vec = 3'b111; fifo_full_vec = 3'b000;
      for (int c = 0; c < 7; c++) begin
         if (c == 4) pkt_valid = 1'b0;
         step();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL basic_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         checks++;
         if (obs_phase() !== exp_ph[c] || (write_enb_reg && write_enb !== 3'b010)) begin
            failures++;
            $display("FAIL basic_phase c=%0d got=%0d/%b exp=%0d/010", c, obs_phase(), write_enb, exp_ph[c]);
         end
      end
   endtask

   task automatic test_addr3();
      pkt_valid = 1'b1; addr = 2'd3; fifo_full_vec = 3'b010;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL addr3_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         checks++;
         if ({detect_addr, busy, write_enb, fifo_full} !== {1'b1, 1'b0, 3'b000, 1'b1}) begin
            failures++;
            $display("FAIL addr3_hold c=%0d got=%b exp=1_0_000_1", c, {detect_addr, busy, write_enb, fifo_full});
         end
      end
      pkt_valid = 1'b0; fifo_full_vec = 3'b000;
   endtask

   task automatic test_wait_empty();
      int exp_ph[7] = '{P_WTE, P_WTE, P_LFD, P_LD, P_LP, P_CPE, P_DEC};
      pkt_valid = 1'b1; addr = 2'd2; fifo_empty_vec = 3'b011;
      for (int c = 0; c < 7; c++) begin
         if (c == 2) fifo_empty_vec = 3'b111;
         if (c == 3) pkt_valid = 1'b0;
         step();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL wait_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         checks++;
         if (obs_phase() !== exp_ph[c] || (c < 2 && busy !== 1'b1)) begin
            failures++; $display("FAIL wait_phase c=%0d got=%0d busy=%b exp=%0d", c, obs_phase(), busy, exp_ph[c]);
         end
      end
   endtask

   task automatic test_fifo_full();
      int exp_ph[8] = '{P_LFD, P_LD, P_FF, P_FF, P_LAF, P_LP, P_CPE, P_DEC};
      pkt_valid = 1'b1; addr = 2'd0; fifo_empty_vec = 3'b111; fifo_full_vec = 3'b000;
      for (int c = 0; c < 8; c++) begin
         if (c == 2) fifo_full_vec = 3'b001;
         if (c == 4) begin fifo_full_vec = 3'b000; low_pkt_valid = 1'b1; pkt_valid = 1'b0; end
         step();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL full_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         checks++;
         if (obs_phase() !== exp_ph[c] || (full_state && write_enb !== 3'b000)) begin
            failures++; $display("FAIL full_phase c=%0d got=%0d we=%b exp=%0d", c, obs_phase(), write_enb, exp_ph[c]);
         end
      end
      low_pkt_valid = 1'b0;
   endtask

   task automatic test_timeout();
      int seen = -1;
      int pulses = 0;
      pkt_valid = 1'b1; addr = 2'd1; fifo_empty_vec = 3'b111; read_enb = 3'b000;
      step(); step();
      fifo_empty_vec = 3'b101;
      for (int c = 1; c <= 40; c++) begin
         step();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL tmo_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (soft_reset[1]) begin
            pulses++;
            if (seen < 0) seen = c;
         end
         if (c == TIMEOUT + 1) begin
            checks++;
            if (detect_addr !== 1'b1) begin
               failures++; $display("FAIL tmo_abort got=%b exp=1", detect_addr);
            end
         end
      end
      checks++;
      if (seen !== TIMEOUT || pulses !== 1) begin
         failures++; $display("FAIL tmo_latency got=%0d/%0d exp=%0d/1", seen, pulses, TIMEOUT);
      end
      fifo_empty_vec = 3'b111; pkt_valid = 1'b0;
      for (int c = 0; c < 6; c++) step();
      fifo_empty_vec = 3'b101;
      for (int c = 1; c <= TIMEOUT + 10; c++) begin
         read_enb = (c == TIMEOUT) ? 3'b010 : 3'b000;
         step();
         checks++;
         if (dut_vec() !== exp_vec() || soft_reset[1] !== 1'b0) begin
            failures++; $display("FAIL tmo_read_wins c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
      end
      read_enb = 3'b000; fifo_empty_vec = 3'b111;
      step();
   endtask

   task automatic test_pkt_count();
      logic [7:0] exp255;
`ifdef ROUTER_PKT_CNT_EN
      exp255 = 8'd255;
`else
      exp255 = 8'd0;
`endif
      rstn = 1'b0; step(); rstn = 1'b1;
      fifo_empty_vec = 3'b111; fifo_full_vec = 3'b000; addr = 2'd0;
      for (int p = 0; p < 256; p++) begin
         for (int c = 0; c < 5; c++) begin
            pkt_valid = (c == 0);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
               failures++; $display("FAIL cnt_model p=%0d c=%0d got=%h exp=%h", p, c, dut_vec(), exp_vec());
            end
         end
         if (p == 254) begin
            checks++;
            if (pkt_count[7:0] !== exp255) begin
               failures++; $display("FAIL cnt_255 got=%0d exp=%0d", pkt_count[7:0], exp255);
            end
         end
      end
      checks++;
      if (pkt_count[7:0] !== 8'd0) begin
         failures++; $display("FAIL cnt_wrap got=%0d exp=0", pkt_count[7:0]);
      end
      pkt_valid = 1'b1; addr = 2'd1;
      step(); step();
      rstn = 1'b0;
      step();
      checks++;
      if ({detect_addr, pkt_count} !== {1'b1, 24'd0} || dut_vec() !== exp_vec()) begin
         failures++; $display("FAIL mid_reset got=%h exp=%h", dut_vec(), exp_vec());
      end
      rstn = 1'b1; pkt_valid = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         rstn          = ($urandom_range(0, 599) != 0);
         pkt_valid     = ($urandom_range(0, 3) != 0);
         addr          = 2'($urandom_range(0, 3));
         parity_done   = ($urandom_range(0, 3) == 0);
         low_pkt_valid = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 3; i++) begin
            fifo_full_vec[i] = ($urandom_range(0, 5) == 0);
            read_enb[i]      = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) fifo_empty_vec[i] = ~fifo_empty_vec[i];
         end
         step();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL random_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_packet();
      test_addr3();
      test_wait_empty();
      test_fifo_full();
      test_timeout();
      test_pkt_count();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/router_ctrl_fsm.md
Name: router_ctrl_fsm

Overview:
- Packet-sequencing controller for the 1-input/3-output router datapath.
- Decodes the destination from the header byte and selects the target output FIFO.
- Drives the datapath register stage's phase strobes (detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg) and the FIFO write enables.
- Watches each output port for read timeout and issues per-port soft reset.

Parameters:
TIMEOUT, 30, cycles a non-empty output FIFO may go unread before soft_reset pulses (must be >= 2)
CNT_W, 5, width of each timeout counter (2**CNT_W >= TIMEOUT)

Ports:
clk  input  1  clock; all logic on rising edge
rstn  input  1  synchronous active-low reset
pkt_valid  input  1  source packet-valid
addr  input  2  data_in[1:0] of current input byte (header destination)
fifo_full_vec  input  3  full flags of output FIFOs 0..2
fifo_empty_vec  input  3  empty flags of output FIFOs 0..2
read_enb  input  3  per-port read strobes from destination clients
parity_done  input  1  from register stage
low_pkt_valid  input  1  from register stage
fifo_full  output  1  fifo_full_vec[port_sel]
detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg  output  1 each  phase strobes to register stage
write_enb_reg  output  1  datapath write phase active
write_enb  output  3  one-hot FIFO write enable
busy  output  1  source must hold data
vld_out  output  3  ~fifo_empty_vec
soft_reset  output  3  one-cycle per-port timeout reset
pkt_count  output  24  per-port packet counters (see Optional Feature)

Behaviour:
- Reset: rstn sampled on clk only (synchronous, active-low); highest priority. State=DECODE_ADDRESS, port_sel=0, all counters 0, soft_reset=0.
- port_sel (2b reg): loaded with addr in DECODE_ADDRESS when pkt_valid && addr!=3; held otherwise.
- State transitions:
  - DECODE_ADDRESS:
    - pkt_valid && addr!=3 && fifo_empty_vec[addr] -> LOAD_FIRST_DATA
    - pkt_valid && addr!=3 && !fifo_empty_vec[addr] -> WAIT_TILL_EMPTY
    - otherwise stay; addr==3 is ignored and not stored.
  - WAIT_TILL_EMPTY: fifo_empty_vec[port_sel] -> LOAD_FIRST_DATA, else stay.
  - LOAD_FIRST_DATA: -> LOAD_DATA unconditionally.
  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS
    - low_pkt_valid -> LOAD_PARITY
    - otherwise -> LOAD_DATA
  - LOAD_PARITY: -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else DECODE_ADDRESS.
- Abort: soft_reset[port_sel]==1 in any state except DECODE_ADDRESS forces next state DECODE_ADDRESS. Abort overrides all other transitions.
- Outputs are Moore, decoded combinationally from the state register:
  - detect_addr = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - ld_state = LOAD_DATA
  - laf_state = LOAD_AFTER_FULL
  - full_state = FIFO_FULL_STATE
  - rst_int_reg = CHECK_PARITY_ERROR
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA
  - write_enb = write_enb_reg ? (3'b001 << port_sel) : 0
- Timeout counter, per port i, independent:
  - Clears when fifo_empty_vec[i] or read_enb[i].
  - Otherwise increments.
  - When count==TIMEOUT-1 and still unread, soft_reset[i]=1 for exactly one cycle and the counter clears the same edge.
  - soft_reset is registered, so it asserts TIMEOUT cycles after vld_out[i] rises with no read.
- A read_enb asserted in the same cycle the count reaches TIMEOUT-1 wins: no pulse, counter clears.

Optional Feature:
Macro: ROUTER_PKT_CNT_EN
- Defined: three 8-bit counters packed into pkt_count[7:0]=port0, [15:8]=port1, [23:16]=port2.
  - Counter[port_sel] increments on every cycle in CHECK_PARITY_ERROR.
  - Wraps 255->0; cleared by rstn only.
- Undefined: pkt_count tied to 24'd0; no counter flops.

Test Plan:
1. Reset, then header addr=1, FIFO1 empty, pkt_valid high 4 cycles -> states DECODE, LFD, LOAD_DATA x3, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE. write_enb=3'b010 during LD/LP; rst_int_reg high 1 cycle.
2. Header addr=3 with pkt_valid -> stays DECODE_ADDRESS, busy=0, write_enb=0, port_sel unchanged.
3. Header addr=2 with fifo_empty_vec[2]=0 -> WAIT_TILL_EMPTY, busy=1. Drop empty[2] to 1 -> LOAD_FIRST_DATA next cycle.
4. fifo_full_vec[0]=1 in LOAD_DATA (port 0) -> FIFO_FULL_STATE, full_state=1, write_enb=0. Release full with low_pkt_valid=1, parity_done=0 -> LOAD_AFTER_FULL, then LOAD_PARITY.
5. fifo_empty_vec[1]=0 with no read_enb, TIMEOUT=30 -> soft_reset[1] single-cycle pulse 30 cycles later. If the FSM is mid-packet on port 1, next state is DECODE_ADDRESS. read_enb[1] at cycle 29 -> no pulse.
6. With ROUTER_PKT_CNT_EN, send 256 packets to port 0 -> pkt_count[7:0] wraps to 0. rstn low mid-packet -> DECODE_ADDRESS and all counters 0 next edge.
